// File: rtl/pattern_bank_pkg.sv
// pbank_pkg: shared defaults and select-FSM state type for the pattern bank.
// Optional parity storage is enabled by defining PBANK_PARITY_EN.
package pbank_pkg;

  localparam int PBANK_NO_BUFS   = 8;
  localparam int PBANK_BUF_SIZE  = 22;
  localparam int PBANK_BUF_WIDTH = 8;

  typedef enum logic {
    SEL_IDLE    = 1'b0,
    SEL_PENDING = 1'b1
  } pbank_sel_state_t;

endpackage

// File: rtl/pattern_bank_if.sv
// pattern_bank_if: scan, select and field-port signals of the pattern bank.
// master = sequence controller / scan loader side, slave = the bank.
interface pattern_bank_if #(
  parameter int NO_BUFS   = pbank_pkg::PBANK_NO_BUFS,
  parameter int BUF_SIZE  = pbank_pkg::PBANK_BUF_SIZE,
  parameter int BUF_WIDTH = pbank_pkg::PBANK_BUF_WIDTH
);
  localparam int SELW = $clog2(NO_BUFS);
  localparam int ADRW = $clog2(BUF_SIZE);

  // scan chain
  logic                          sin;
  logic                          sshift;
  logic                          ssel;
  logic [SELW-1:0]               saddr;
  logic                          sout;
  logic                          scan_lost;
  // buffer select handshake
  logic [SELW-1:0]               buf_sel_next;
  logic                          buf_sel_req;
  logic                          frame_sync;
  logic                          buf_sel_ack;
  logic                          sel_err;
  logic [SELW-1:0]               cur_sel;
  logic [BUF_SIZE*BUF_WIDTH-1:0] current_buffer;
  // field port
  logic [SELW-1:0]               bufp;
  logic [ADRW-1:0]               fieldp;
  logic                          field_rd;
  logic [BUF_WIDTH-1:0]          field_byte;
  logic                          field_valid;
  logic [ADRW-1:0]               fieldwp;
  logic [BUF_WIDTH-1:0]          field_in;
  logic                          field_write;
  logic                          parity_err;

  modport master (
    output sin, sshift, ssel, saddr, buf_sel_next, buf_sel_req, frame_sync,
           bufp, fieldp, field_rd, fieldwp, field_in, field_write,
    input  sout, scan_lost, buf_sel_ack, sel_err, cur_sel, current_buffer,
           field_byte, field_valid, parity_err
  );

  modport slave (
    input  sin, sshift, ssel, saddr, buf_sel_next, buf_sel_req, frame_sync,
           bufp, fieldp, field_rd, fieldwp, field_in, field_write,
    output sout, scan_lost, buf_sel_ack, sel_err, cur_sel, current_buffer,
           field_byte, field_valid, parity_err
  );

endinterface

// File: rtl/pattern_bank_store.sv
// pattern_store: one pattern store. Bytes form a single shift chain (sin into
// byte 0 bit 0, MSB of the last byte out), plus a byte write port, a
// combinational read mux and a flattened contents view.
// With PBANK_PARITY_EN each byte also keeps an even-parity bit.
module pattern_store #(
  parameter int BUF_SIZE  = 22,
  parameter int BUF_WIDTH = 8,
  parameter int ADRW      = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          shift_en,
  input  logic                          sin,
  input  logic                          wr_en,
  input  logic [ADRW-1:0]               wr_addr,
  input  logic [BUF_WIDTH-1:0]          wr_data,
  input  logic [ADRW-1:0]               rd_addr,
  output logic                          msb,
  output logic [BUF_WIDTH-1:0]          rd_byte,
  output logic                          rd_perr,
  output logic [BUF_SIZE*BUF_WIDTH-1:0] contents
);

  logic [BUF_WIDTH-1:0] byte_view [BUF_SIZE];
`ifdef PBANK_PARITY_EN
  logic                 perr_view [BUF_SIZE];
`endif

  genvar gi;
  generate
    for (gi = 0; gi < BUF_SIZE; gi++) begin : g_byte
      logic [BUF_WIDTH-1:0] byte_reg;
      logic                 carry;
      logic [BUF_WIDTH-1:0] shift_next;

      if (gi == 0) begin : g_first
        assign carry = sin;
      end else begin : g_rest
        assign carry = byte_view[gi-1][BUF_WIDTH-1];
      end

      assign shift_next = {byte_reg[BUF_WIDTH-2:0], carry};

      // Byte register: a write always wins; the caller never enables both.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          byte_reg <= '0;
        else if (wr_en && (wr_addr == ADRW'(gi)))
          byte_reg <= wr_data;
        else if (shift_en)
          byte_reg <= shift_next;
      end

      assign byte_view[gi] = byte_reg;
      assign contents[gi*BUF_WIDTH +: BUF_WIDTH] = byte_reg;

`ifdef PBANK_PARITY_EN
      logic par_reg;

      // Parity follows whatever value the byte register is loaded with.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          par_reg <= 1'b0;
        else if (wr_en && (wr_addr == ADRW'(gi)))
          par_reg <= ^wr_data;
        else if (shift_en)
          par_reg <= ^shift_next;
      end

      assign perr_view[gi] = par_reg ^ (^byte_reg);
`endif
    end
  endgenerate

  assign msb     = byte_view[BUF_SIZE-1][BUF_WIDTH-1];
  assign rd_byte = (32'(rd_addr) < BUF_SIZE) ? byte_view[rd_addr] : '0;
`ifdef PBANK_PARITY_EN
  assign rd_perr = (32'(rd_addr) < BUF_SIZE) ? perr_view[rd_addr] : 1'b0;
`else
  assign rd_perr = 1'b0;
`endif

endmodule

// File: rtl/pattern_bank.sv
// pattern_bank: NO_BUFS pattern stores with scan and field access, a
// registered field read port and a frame-synchronised active-store select.
// Define PBANK_PARITY_EN to enable per-byte parity checking on reads.
module pattern_bank
  import pbank_pkg::*;
#(
  parameter int NO_BUFS   = PBANK_NO_BUFS,
  parameter int BUF_SIZE  = PBANK_BUF_SIZE,
  parameter int BUF_WIDTH = PBANK_BUF_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  pattern_bank_if.slave bus
);

  localparam int SELW  = $clog2(NO_BUFS);
  localparam int ADRW  = $clog2(BUF_SIZE);
  localparam int NBITS = BUF_SIZE * BUF_WIDTH;

  logic [NO_BUFS-1:0]   shift_req, wr_req, shift_en, msb_vec, perr_vec;
  logic [BUF_WIDTH-1:0] rd_bytes [NO_BUFS];
  logic [NBITS-1:0]     contents [NO_BUFS];

  logic                 wr_in_range;
  logic                 req_ok;
  logic                 collision;
  logic                 sout_mux, perr_mux;
  logic [BUF_WIDTH-1:0] rd_mux;
  logic [NBITS-1:0]     cur_mux;

  pbank_sel_state_t     state_reg;
  logic [SELW-1:0]      pend_reg, cur_sel_reg;
  logic                 buf_sel_ack_reg, sel_err_reg, scan_lost_reg;
  logic [BUF_WIDTH-1:0] field_byte_reg;
  logic                 field_valid_reg, parity_err_reg;

  assign wr_in_range = bus.field_write && (32'(bus.fieldwp) < BUF_SIZE);
  assign req_ok      = bus.buf_sel_req && (32'(bus.buf_sel_next) < NO_BUFS);

  genvar gi;
  generate
    for (gi = 0; gi < NO_BUFS; gi++) begin : g_store
      assign shift_req[gi] = bus.ssel && bus.sshift && (bus.saddr == SELW'(gi));
      assign wr_req[gi]    = wr_in_range && (bus.bufp == SELW'(gi));
      // A colliding write takes the cycle; the store's shift is dropped.
      assign shift_en[gi]  = shift_req[gi] && !wr_req[gi];

      pattern_store #(
        .BUF_SIZE (BUF_SIZE),
        .BUF_WIDTH(BUF_WIDTH),
        .ADRW     (ADRW)
      ) u_store (
        .clk     (clk),
        .rst     (rst),
        .shift_en(shift_en[gi]),
        .sin     (bus.sin),
        .wr_en   (wr_req[gi]),
        .wr_addr (bus.fieldwp),
        .wr_data (bus.field_in),
        .rd_addr (bus.fieldp),
        .msb     (msb_vec[gi]),
        .rd_byte (rd_bytes[gi]),
        .rd_perr (perr_vec[gi]),
        .contents(contents[gi])
      );
    end
  endgenerate

  assign collision = |(shift_req & wr_req);

  // Store-index muxes; indices with no store select zero.
  always_comb begin
    sout_mux = 1'b0;
    rd_mux   = '0;
    perr_mux = 1'b0;
    cur_mux  = '0;
    for (int i = 0; i < NO_BUFS; i++) begin
      if (bus.saddr == SELW'(i))   sout_mux = msb_vec[i];
      if (bus.bufp == SELW'(i)) begin
        rd_mux   = rd_bytes[i];
        perr_mux = perr_vec[i];
      end
      if (cur_sel_reg == SELW'(i)) cur_mux = contents[i];
    end
  end

  // Field read register and scan-collision flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      field_byte_reg  <= '0;
      field_valid_reg <= 1'b0;
      parity_err_reg  <= 1'b0;
      scan_lost_reg   <= 1'b0;
    end else begin
      field_valid_reg <= bus.field_rd;
      parity_err_reg  <= bus.field_rd && perr_mux;
      scan_lost_reg   <= collision;
      if (bus.field_rd) field_byte_reg <= rd_mux;
    end
  end

  // Select FSM: a request parks in PENDING until frame_sync commits it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= SEL_IDLE;
      pend_reg        <= '0;
      cur_sel_reg     <= '0;
      buf_sel_ack_reg <= 1'b0;
      sel_err_reg     <= 1'b0;
    end else begin
      buf_sel_ack_reg <= 1'b0;
      sel_err_reg     <= bus.buf_sel_req && !req_ok;
      if (bus.frame_sync && (req_ok || state_reg == SEL_PENDING)) begin
        cur_sel_reg     <= req_ok ? bus.buf_sel_next : pend_reg;
        buf_sel_ack_reg <= 1'b1;
        state_reg       <= SEL_IDLE;
      end else if (req_ok) begin
        pend_reg  <= bus.buf_sel_next;
        state_reg <= SEL_PENDING;
      end
    end
  end

  assign bus.sout           = bus.ssel && sout_mux;
  assign bus.scan_lost      = scan_lost_reg;
  assign bus.buf_sel_ack    = buf_sel_ack_reg;
  assign bus.sel_err        = sel_err_reg;
  assign bus.cur_sel        = cur_sel_reg;
  assign bus.current_buffer = cur_mux;
  assign bus.field_byte     = field_byte_reg;
  assign bus.field_valid    = field_valid_reg;
  assign bus.parity_err     = parity_err_reg;

endmodule
